// File: rtl/branch_pkg.sv
// Shared encodings for the branch predict unit.
// Branch ops, 2-bit counter states, FSM states.
package branch_pkg;

  typedef enum logic [2:0] {
    OP_BEQ  = 3'b000,
    OP_BNE  = 3'b001,
    OP_JAL  = 3'b010,
    OP_UND  = 3'b011,
    OP_BLT  = 3'b100,
    OP_BGE  = 3'b101,
    OP_BLTU = 3'b110,
    OP_BGEU = 3'b111
  } br_op_e;

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } bpu_state_e;

  function automatic logic is_cond(
    input logic [2:0] op
  );
    return (op != OP_JAL) && (op != OP_UND);
  endfunction

  function automatic logic [1:0] cnt_next(
    input logic [1:0] c,
    input logic       t
  );
    logic [1:0] n;
    n = c;
    if (t && c != CNT_ST)
      n = c + 2'b01;
    else if (!t && c != CNT_SNT)
      n = c - 2'b01;
    return n;
  endfunction

endpackage

// File: rtl/branch_compare.sv
// Branch condition evaluator (combinational).
// Ports: i_op, i_a, i_b in; o_res out.
module branch_compare
  import branch_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            i_op,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic                  o_res
);

  logic w_eq;
  logic w_lt;
  logic w_ltu;

  assign w_eq  = (i_a == i_b);
  assign w_lt  = ($signed(i_a) < $signed(i_b));
  assign w_ltu = (i_a < i_b);

  always_comb begin
    o_res = 1'b0;
    unique case (1'b1)
      (i_op == OP_BEQ):  o_res = w_eq;
      (i_op == OP_BNE):  o_res = ~w_eq;
      (i_op == OP_JAL):  o_res = 1'b1;
      (i_op == OP_UND):  o_res = 1'b0;
      (i_op == OP_BLT):  o_res = w_lt;
      (i_op == OP_BGE):  o_res = ~w_lt;
      (i_op == OP_BLTU): o_res = w_ltu;
      (i_op == OP_BGEU): o_res = ~w_ltu;
      default:           o_res = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Bimodal predictor, resolver, stats, flush sweep.
// Ports: fetch pc/pred, resolve req/result, flush, ready, counters.
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_fetch_pc,
  output logic                  o_pred_taken,
  input  logic                  i_valid,
  input  logic                  i_branch,
  input  logic [2:0]            i_branch_op,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  logic [DATA_WIDTH-1:0] i_ex_pc,
  input  logic                  i_pred_taken,
  input  logic                  i_flush,
  output logic                  o_valid,
  output logic                  o_take,
  output logic                  o_mispredict,
  output logic                  o_ready,
  output logic [CNT_WIDTH-1:0]  o_branch_cnt,
  output logic [CNT_WIDTH-1:0]  o_mispred_cnt
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(BHT_ENTRIES - 1);

  logic [1:0]       r_bht [BHT_ENTRIES];
  bpu_state_e       r_state;
  bpu_state_e       w_state_nxt;
  logic [IDX_W-1:0] r_sweep;
  logic [IDX_W-1:0] w_sweep_nxt;
  logic             w_clr_en;

  logic [IDX_W-1:0] w_fidx;
  logic [IDX_W-1:0] w_eidx;
  logic             w_cmp;
  logic             w_take;
  logic             w_mis;
  logic             w_qual;
  logic             w_ready;
  logic             w_upd;
  logic             w_unused;

  logic                 r_valid;
  logic                 r_take;
  logic                 r_mis;
  logic [CNT_WIDTH-1:0] r_bcnt;
  logic [CNT_WIDTH-1:0] r_mcnt;

  assign w_unused = ^{i_fetch_pc, i_ex_pc};

  assign w_fidx = i_fetch_pc[IDX_W+1:2];
  assign w_eidx = i_ex_pc[IDX_W+1:2];

  assign o_pred_taken = r_bht[w_fidx][1];

  branch_compare #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_cmp (
    .i_op (i_branch_op),
    .i_a  (i_a),
    .i_b  (i_b),
    .o_res(w_cmp)
  );

  assign w_take  = i_branch & w_cmp;
  assign w_mis   = w_take ^ i_pred_taken;
  assign w_qual  = i_valid & i_branch
                 & is_cond(i_branch_op);
  assign w_ready = (r_state == ST_IDLE);
  // A flush in the same cycle wins over the update.
  assign w_upd   = w_qual & w_ready & ~i_flush;

  always_comb begin
    w_state_nxt = r_state;
    w_sweep_nxt = r_sweep;
    w_clr_en    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (i_flush) begin
          w_state_nxt = ST_CLEAR;
          w_sweep_nxt = '0;
        end
      end
      ST_CLEAR: begin
        w_clr_en    = 1'b1;
        w_sweep_nxt = r_sweep + 1'b1;
        if (r_sweep == LAST_IDX)
          w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_sweep <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sweep <= w_sweep_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++)
        r_bht[i] <= CNT_WNT;
    end else if (w_clr_en) begin
      r_bht[r_sweep] <= CNT_WNT;
    end else if (w_upd) begin
      r_bht[w_eidx] <= cnt_next(r_bht[w_eidx], w_take);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_take  <= 1'b0;
      r_mis   <= 1'b0;
    end else begin
      r_valid <= i_valid;
      r_take  <= i_valid & w_take;
      r_mis   <= i_valid & w_mis;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bcnt <= '0;
      r_mcnt <= '0;
    end else begin
      if (w_qual && !(&r_bcnt))
        r_bcnt <= r_bcnt + 1'b1;
      if (w_qual && w_mis && !(&r_mcnt))
        r_mcnt <= r_mcnt + 1'b1;
    end
  end

  assign o_valid       = r_valid;
  assign o_take        = r_take;
  assign o_mispredict  = r_mis;
  assign o_ready       = w_ready;
  assign o_branch_cnt  = r_bcnt;
  assign o_mispred_cnt = r_mcnt;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit.
// Eight-entry table; immediate assertions per check.
module tb_branch_predict_unit;

  localparam int DW = 32;
  localparam int NE = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] fetch_pc;
  logic          pred;
  logic          valid;
  logic          branch;
  logic [2:0]    op;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic [DW-1:0] ex_pc;
  logic          pred_in;
  logic          flush;
  logic          ovalid;
  logic          take;
  logic          mis;
  logic          ready;
  logic [CW-1:0] bcnt;
  logic [CW-1:0] mcnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_predict_unit #(
    .DATA_WIDTH (DW),
    .BHT_ENTRIES(NE),
    .CNT_WIDTH  (CW)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_fetch_pc   (fetch_pc),
    .o_pred_taken (pred),
    .i_valid      (valid),
    .i_branch     (branch),
    .i_branch_op  (op),
    .i_a          (a),
    .i_b          (b),
    .i_ex_pc      (ex_pc),
    .i_pred_taken (pred_in),
    .i_flush      (flush),
    .o_valid      (ovalid),
    .o_take       (take),
    .o_mispredict (mis),
    .o_ready      (ready),
    .o_branch_cnt (bcnt),
    .o_mispred_cnt(mcnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic resolve(
    input logic [2:0]    o,
    input logic [DW-1:0] va,
    input logic [DW-1:0] vb,
    input logic [DW-1:0] pc,
    input logic          p,
    input logic          br
  );
    valid   = 1'b1;
    branch  = br;
    op      = o;
    a       = va;
    b       = vb;
    ex_pc   = pc;
    pred_in = p;
    tick();
    valid   = 1'b0;
  endtask

  task automatic chk_out(
    input string tag,
    input logic  v,
    input logic  t,
    input logic  m
  );
    chk({tag, "_valid"}, 32'(ovalid), 32'(v));
    chk({tag, "_take"},  32'(take),   32'(t));
    chk({tag, "_mis"},   32'(mis),    32'(m));
  endtask

  task automatic chk_cnt(
    input string       tag,
    input logic [31:0] eb,
    input logic [31:0] em
  );
    chk({tag, "_bcnt"}, 32'(bcnt), eb);
    chk({tag, "_mcnt"}, 32'(mcnt), em);
  endtask

  task automatic chk_all01(input string tag);
    for (int i = 0; i < NE; i++) begin
      fetch_pc = 32'(i * 4);
      #1;
      chk({tag, "_pred"}, 32'(pred), 32'd0);
      chk({tag, "_ent"}, 32'(dut.r_bht[i]), 32'd1);
    end
  endtask

  initial begin
    rst = 1'b1;
    fetch_pc = 32'h40;
    valid = 1'b0;
    branch = 1'b0;
    op = 3'b000;
    a = '0;
    b = '0;
    ex_pc = '0;
    pred_in = 1'b0;
    flush = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_pred", 32'(pred), 32'd0);
    chk_cnt("rst", 32'd0, 32'd0);
    chk_out("rst", 1'b0, 1'b0, 1'b0);
    chk("rst_ready", 32'(ready), 32'd1);

    // Three taken BEQ at 0x40, prediction fed back
    resolve(3'b000, 32'd5, 32'd5, 32'h40, 1'b0, 1'b1);
    chk_out("beq1", 1'b1, 1'b1, 1'b1);
    chk("beq1_ent", 32'(dut.r_bht[0]), 32'd2);
    chk("beq1_pred", 32'(pred), 32'd1);
    resolve(3'b000, 32'd5, 32'd5, 32'h40, 1'b1, 1'b1);
    chk_out("beq2", 1'b1, 1'b1, 1'b0);
    chk("beq2_ent", 32'(dut.r_bht[0]), 32'd3);
    resolve(3'b000, 32'd5, 32'd5, 32'h40, 1'b1, 1'b1);
    chk_out("beq3", 1'b1, 1'b1, 1'b0);
    chk("beq3_ent", 32'(dut.r_bht[0]), 32'd3);
    chk_cnt("beq3", 32'd3, 32'd1);

    // Idle cycle clears the resolve outputs
    tick();
    chk_out("idle", 1'b0, 1'b0, 1'b0);

    // Signed vs unsigned less-than
    resolve(3'b100, 32'hFFFF_FFFF, 32'd1,
            32'h44, 1'b0, 1'b1);
    chk_out("blt", 1'b1, 1'b1, 1'b1);
    chk("blt_ent", 32'(dut.r_bht[1]), 32'd2);
    resolve(3'b110, 32'hFFFF_FFFF, 32'd1,
            32'h44, 1'b1, 1'b1);
    chk_out("bltu", 1'b1, 1'b0, 1'b1);
    chk("bltu_ent", 32'(dut.r_bht[1]), 32'd1);
    chk_cnt("bltu", 32'd5, 32'd3);

    // JAL: taken, no table write, no count
    resolve(3'b010, 32'd1, 32'd2, 32'h48, 1'b0, 1'b1);
    chk_out("jal", 1'b1, 1'b1, 1'b1);
    chk("jal_ent", 32'(dut.r_bht[2]), 32'd1);
    chk_cnt("jal", 32'd5, 32'd3);

    // Undefined op 011 never takes
    resolve(3'b011, 32'd7, 32'd7, 32'h48, 1'b0, 1'b1);
    chk_out("und", 1'b1, 1'b0, 1'b0);
    chk("und_ent", 32'(dut.r_bht[2]), 32'd1);

    // Not a branch: no take, reports mispredict only
    resolve(3'b000, 32'd7, 32'd7, 32'h48, 1'b1, 1'b0);
    chk_out("nobr", 1'b1, 1'b0, 1'b1);
    chk("nobr_ent", 32'(dut.r_bht[2]), 32'd1);
    chk_cnt("nobr", 32'd5, 32'd3);

    // Not-taken BEQ saturates at 00
    resolve(3'b000, 32'd1, 32'd2, 32'h48, 1'b0, 1'b1);
    chk("nt1_ent", 32'(dut.r_bht[2]), 32'd0);
    resolve(3'b000, 32'd1, 32'd2, 32'h48, 1'b0, 1'b1);
    chk_out("nt2", 1'b1, 1'b0, 1'b0);
    chk("nt2_ent", 32'(dut.r_bht[2]), 32'd0);
    chk_cnt("nt2", 32'd7, 32'd3);

    // Flush with a same-cycle update: flush wins
    fetch_pc = 32'h40;
    flush = 1'b1;
    resolve(3'b000, 32'd3, 32'd3, 32'h4C, 1'b0, 1'b1);
    chk("fl0_ready", 32'(ready), 32'd0);
    chk_out("fl0", 1'b1, 1'b1, 1'b1);
    chk("fl0_ent3", 32'(dut.r_bht[3]), 32'd1);
    chk("fl0_pred", 32'(pred), 32'd1);
    chk_cnt("fl0", 32'd8, 32'd4);

    // Seven more sweep cycles; flush held early
    for (int i = 1; i < NE; i++) begin
      flush = (i <= 3);
      if (i == 2) begin
        resolve(3'b001, 32'd1, 32'd2,
                32'h5C, 1'b0, 1'b1);
        chk_out("bne_mid", 1'b1, 1'b1, 1'b1);
        chk("bne_mid_ent7", 32'(dut.r_bht[7]), 32'd1);
        chk_cnt("bne_mid", 32'd9, 32'd5);
      end else begin
        tick();
      end
      chk($sformatf("fl%0d_ready", i),
          32'(ready), 32'd0);
    end
    flush = 1'b0;
    tick();
    chk("fl_done_ready", 32'(ready), 32'd1);
    chk_all01("fl_done");
    tick();
    chk("fl_stay_ready", 32'(ready), 32'd1);

    // Reset in the middle of a sweep
    resolve(3'b000, 32'd9, 32'd9, 32'h58, 1'b0, 1'b1);
    resolve(3'b000, 32'd9, 32'd9, 32'h58, 1'b0, 1'b1);
    chk("pre_rst_ent6", 32'(dut.r_bht[6]), 32'd3);
    chk_cnt("pre_rst", 32'd11, 32'd7);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    tick();
    chk("mid_ready", 32'(ready), 32'd0);
    rst = 1'b1;
    flush = 1'b1;
    resolve(3'b000, 32'd9, 32'd9, 32'h58, 1'b0, 1'b1);
    rst = 1'b0;
    flush = 1'b0;
    chk("mrst_ready", 32'(ready), 32'd1);
    chk_out("mrst", 1'b0, 1'b0, 1'b0);
    chk_cnt("mrst", 32'd0, 32'd0);
    chk_all01("mrst");
    tick();
    chk("mrst_idle_ready", 32'(ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
